// File: rtl/foc_loop_scheduler_pkg.sv
// Stage codes, FSM state encodings and the enable bundle shared by the FOC
// sequencer and the transform / PI / SVPWM blocks it drives.
package foc_loop_scheduler_pkg;

  localparam logic [2:0] STG_NONE  = 3'd0;
  localparam logic [2:0] STG_ADC   = 3'd1;
  localparam logic [2:0] STG_CLARK = 3'd2;
  localparam logic [2:0] STG_PARK  = 3'd3;
  localparam logic [2:0] STG_SPD   = 3'd4;
  localparam logic [2:0] STG_CUR   = 3'd5;
  localparam logic [2:0] STG_IPARK = 3'd6;
  localparam logic [2:0] STG_MOD   = 3'd7;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_ADC   = 4'd1;
  localparam logic [3:0] ST_CLARK = 4'd2;
  localparam logic [3:0] ST_PARK  = 4'd3;
  localparam logic [3:0] ST_SPD   = 4'd4;
  localparam logic [3:0] ST_CUR   = 4'd5;
  localparam logic [3:0] ST_IPARK = 4'd6;
  localparam logic [3:0] ST_MOD   = 4'd7;
  localparam logic [3:0] ST_FAULT = 4'd8;

  typedef struct packed {
    logic adc;
    logic clark;
    logic park;
    logic spd;
    logic cur;
    logic ipark;
    logic modulate;
  } stage_en_t;

  // Stage states share their encoding with the stage code they report.
  function automatic logic [2:0] stage_code(input logic [3:0] st);
    return (st >= ST_ADC && st <= ST_MOD) ? st[2:0] : STG_NONE;
  endfunction

  function automatic logic is_busy(input logic [3:0] st);
    return (st != ST_IDLE) && (st != ST_FAULT);
  endfunction

endpackage

// File: rtl/foc_loop_scheduler_watch.sv
// Shared done-edge detector and per-stage timeout counter; the active stage
// selects which done level is watched.
module foc_stage_watch
  import foc_loop_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       clear,
  input  logic [2:0] sel,
  input  logic [5:0] done,
  output logic       done_edge,
  output logic       timeout
);

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  logic [5:0]  done_q;
  logic [5:0]  edge_vec;
  logic [15:0] cnt_q;

  // Every done input keeps its own history so a level already high on
  // stage entry is not mistaken for completion.
  assign edge_vec = done & ~done_q;

  always_comb begin
    done_edge = 1'b0;
    case (sel)
      STG_ADC:   done_edge = edge_vec[0];
      STG_CLARK: done_edge = edge_vec[1];
      STG_PARK:  done_edge = edge_vec[2];
      STG_SPD:   done_edge = edge_vec[3];
      STG_CUR:   done_edge = edge_vec[4];
      STG_IPARK: done_edge = edge_vec[5];
      default:   done_edge = 1'b0;
    endcase
  end

  assign timeout = (cnt_q == TO_VAL) && !done_edge;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      done_q <= '0;
      cnt_q  <= '0;
    end else begin
      done_q <= done;
      if (clear) begin
        cnt_q <= '0;
      end else if (cnt_q != TO_VAL) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/foc_loop_scheduler.sv
// One field-oriented-control iteration per PWM period: ADC, Clark, Park,
// optional speed PI, current PI, inverse Park and modulation, in order.
module foc_loop_scheduler
  import foc_loop_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 4000,
  parameter int unsigned SPEED_DIV = 10
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iRun,
  input  logic       iFault_clr,
  input  logic       iSync,
  input  logic       iAdc_done,
  input  logic       iClark_done,
  input  logic       iPark_done,
  input  logic       iSpd_done,
  input  logic       iCur_done,
  input  logic       iInv_park_done,
  output logic       oAdc_start,
  output logic       oClark_en,
  output logic       oPark_en,
  output logic       oSpd_pi_en,
  output logic       oCur_pi_en,
  output logic       oInv_park_en,
  output logic       oModulate_en,
  output logic       oBusy,
  output logic       oFault,
  output logic [2:0] oFault_stage,
  output logic [7:0] oOverrun_cnt
);

  localparam logic [7:0] SPD_LAST = 8'(SPEED_DIV - 1);

  logic [3:0] state_q, state_d;
  logic       started_q;
  logic [7:0] spd_cnt_q;
  logic       sync_q;
  logic       sync_edge;
  logic [7:0] ovr_q;
  stage_en_t  en_q, en_d;
  logic       busy_q;
  logic       fault_q;
  logic [2:0] fault_stage_q;
  logic       done_edge;
  logic       timeout;
  logic       watch_clear;

  assign sync_edge   = iSync & ~sync_q;
  assign watch_clear = (state_d != state_q);

  foc_stage_watch #(
    .TIMEOUT(TIMEOUT)
  ) u_watch (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .clear    (watch_clear),
    .sel      (stage_code(state_q)),
    .done     ({iInv_park_done, iCur_done, iSpd_done, iPark_done, iClark_done, iAdc_done}),
    .done_edge(done_edge),
    .timeout  (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iRun && (!started_q || sync_edge)) state_d = ST_ADC;
      end
      ST_ADC: begin
        if (done_edge)    state_d = ST_CLARK;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_CLARK: begin
        if (done_edge)    state_d = ST_PARK;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_PARK: begin
        if (done_edge)    state_d = (spd_cnt_q == '0) ? ST_SPD : ST_CUR;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_SPD: begin
        if (done_edge)    state_d = ST_CUR;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_CUR: begin
        if (done_edge)    state_d = ST_IPARK;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_IPARK: begin
        if (done_edge)    state_d = ST_MOD;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_MOD:   state_d = ST_IDLE;
      ST_FAULT: begin
        if (iFault_clr) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Enables are decoded from the upcoming state so each pulse lines up with
  // the first cycle spent in its stage.
  always_comb begin
    en_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_ADC:   en_d.adc      = 1'b1;
        ST_CLARK: en_d.clark    = 1'b1;
        ST_PARK:  en_d.park     = 1'b1;
        ST_SPD:   en_d.spd      = 1'b1;
        ST_CUR:   en_d.cur      = 1'b1;
        ST_IPARK: en_d.ipark    = 1'b1;
        ST_MOD:   en_d.modulate = 1'b1;
        default:  en_d          = '0;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q       <= ST_IDLE;
      started_q     <= 1'b0;
      spd_cnt_q     <= '0;
      sync_q        <= 1'b0;
      ovr_q         <= '0;
      en_q          <= '0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= STG_NONE;
    end else begin
      state_q <= state_d;
      sync_q  <= iSync;
      en_q    <= en_d;
      busy_q  <= is_busy(state_d);
      fault_q <= (state_d == ST_FAULT);

      if (state_d == ST_FAULT) begin
        fault_stage_q <= (state_q == ST_FAULT) ? fault_stage_q : stage_code(state_q);
      end else begin
        fault_stage_q <= STG_NONE;
      end

      if (state_q == ST_IDLE && !iRun) begin
        started_q <= 1'b0;
      end else if (state_q == ST_FAULT && iFault_clr) begin
        started_q <= 1'b0;
      end else if (state_q == ST_IDLE && state_d == ST_ADC) begin
        started_q <= 1'b1;
      end

      if (state_q == ST_IDLE && !iRun) begin
        spd_cnt_q <= '0;
      end else if (state_q == ST_MOD) begin
        spd_cnt_q <= (spd_cnt_q == SPD_LAST) ? '0 : spd_cnt_q + 8'd1;
      end

      if (sync_edge && is_busy(state_q) && ovr_q != 8'hFF) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end
  end

  assign oAdc_start   = en_q.adc;
  assign oClark_en    = en_q.clark;
  assign oPark_en     = en_q.park;
  assign oSpd_pi_en   = en_q.spd;
  assign oCur_pi_en   = en_q.cur;
  assign oInv_park_en = en_q.ipark;
  assign oModulate_en = en_q.modulate;
  assign oBusy        = busy_q;
  assign oFault       = fault_q;
  assign oFault_stage = fault_stage_q;
  assign oOverrun_cnt = ovr_q;

endmodule

// File: tb/tb_foc_loop_scheduler.sv
// Scoreboard bench for foc_loop_scheduler: stimulus pushes expected enable
// codes with their due cycle, a monitor pops them as enables appear.
module tb_foc_loop_scheduler;

  localparam int unsigned TO  = 20;
  localparam int unsigned DIV = 3;

  typedef struct {
    int unsigned code;
    int unsigned cyc;
  } exp_t;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iRun = 1'b0;
  logic       iFault_clr = 1'b0;
  logic       iSync = 1'b0;
  logic       iAdc_done = 1'b0;
  logic       iClark_done = 1'b0;
  logic       iPark_done = 1'b0;
  logic       iSpd_done = 1'b0;
  logic       iCur_done = 1'b0;
  logic       iInv_park_done = 1'b0;
  logic       oAdc_start, oClark_en, oPark_en, oSpd_pi_en, oCur_pi_en;
  logic       oInv_park_en, oModulate_en, oBusy, oFault;
  logic [2:0] oFault_stage;
  logic [7:0] oOverrun_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned n_done = 0;
  int unsigned ovr_exp = 0;
  bit          busy_chk = 1'b0;
  exp_t        exp_q[$];

  foc_loop_scheduler #(
    .TIMEOUT  (TO),
    .SPEED_DIV(DIV)
  ) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iRun          (iRun),
    .iFault_clr    (iFault_clr),
    .iSync         (iSync),
    .iAdc_done     (iAdc_done),
    .iClark_done   (iClark_done),
    .iPark_done    (iPark_done),
    .iSpd_done     (iSpd_done),
    .iCur_done     (iCur_done),
    .iInv_park_done(iInv_park_done),
    .oAdc_start    (oAdc_start),
    .oClark_en     (oClark_en),
    .oPark_en      (oPark_en),
    .oSpd_pi_en    (oSpd_pi_en),
    .oCur_pi_en    (oCur_pi_en),
    .oInv_park_en  (oInv_park_en),
    .oModulate_en  (oModulate_en),
    .oBusy         (oBusy),
    .oFault        (oFault),
    .oFault_stage  (oFault_stage),
    .oOverrun_cnt  (oOverrun_cnt)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_enables"}, {25'd0, oAdc_start, oClark_en, oPark_en, oSpd_pi_en,
                              oCur_pi_en, oInv_park_en, oModulate_en}, 0);
    check({tag, "_busy"}, 32'(oBusy), 0);
    check({tag, "_fault"}, 32'(oFault), 0);
    check({tag, "_fault_stage"}, 32'(oFault_stage), 0);
    check({tag, "_overrun"}, 32'(oOverrun_cnt), 0);
  endtask

  task automatic set_done(input int unsigned code, input logic v);
    case (code)
      1: iAdc_done = v;
      2: iClark_done = v;
      3: iPark_done = v;
      4: iSpd_done = v;
      5: iCur_done = v;
      6: iInv_park_done = v;
      default: ;
    endcase
  endtask

  task automatic push_exp(input int unsigned code, input int unsigned c);
    exp_t e;
    e.code = code;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Reference rule: stage order 1..7; speed PI only on every DIV-th completed
  // sequence since the run was (re)started.
  function automatic int unsigned next_stage(input int unsigned cur, input int unsigned n);
    if (cur == 3) return (n % DIV == 0) ? 4 : 5;
    return cur + 1;
  endfunction

  task automatic wait_consumed(output int unsigned ecyc, output bit ok);
    ok = 1'b0;
    ecyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        ecyc = cyc;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL enable_wait: got no enable code %0d, expected by cycle %0d", exp_q[0].code, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic start_sync(input int unsigned gap);
    repeat (gap) @(posedge iClk);
    #1 iSync = 1'b1;
    push_exp(1, cyc + 1);
    @(posedge iClk);
    #1 iSync = 1'b0;
  endtask

  // special: 0 plain, 1 stop at PARK, 2 sync burst in CLARK, 3 stale CLARK done,
  // 4 stop at CUR, 5 drop iRun during ADC.
  task automatic run_seq(input int unsigned lat_fix, input int unsigned special,
                         output int unsigned last_cyc, output bit ok);
    int unsigned cur, e, nxt, lat;
    bit got;
    cur = 1;
    ok = 1'b1;
    last_cyc = 0;
    forever begin
      wait_consumed(e, got);
      last_cyc = e;
      if (!got) begin
        ok = 1'b0;
        return;
      end
      if (cur == 7) return;
      if (special == 1 && cur == 3) return;
      if (special == 4 && cur == 5) return;
      if (special == 5 && cur == 1) iRun = 1'b0;
      nxt = next_stage(cur, n_done);
      if (special == 2 && cur == 2) begin
        for (int i = 0; i < 8; i++) begin
          @(posedge iClk);
          #1 iSync = 1'b1;
          @(posedge iClk);
          #1 iSync = 1'b0;
          if (ovr_exp < 255) ovr_exp++;
        end
        @(posedge iClk);
        #1;
      end else if (special == 3 && cur == 2) begin
        repeat (4) @(posedge iClk);
        #1 iClark_done = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
      end else begin
        lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 5);
        repeat (lat) @(posedge iClk);
        #1;
      end
      set_done(cur, 1'b1);
      if (special == 3 && cur == 1) iClark_done = 1'b1;
      push_exp(nxt, cyc + 1);
      @(posedge iClk);
      #1 set_done(cur, 1'b0);
      cur = nxt;
    end
  endtask

  initial begin : monitor
    logic [6:0]  en;
    int unsigned code;
    exp_t        e;
    forever begin
      @(negedge iClk);
      if (busy_chk) begin
        check("busy_after_mod", 32'(oBusy), 0);
        busy_chk = 1'b0;
      end
      en = {oModulate_en, oInv_park_en, oCur_pi_en, oSpd_pi_en, oPark_en, oClark_en, oAdc_start};
      if (en != '0) begin
        code = 0;
        if ($countones(en) == 1) begin
          for (int i = 0; i < 7; i++) if (en[i]) code = i + 1;
        end
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_enable: got enable vector %b, expected none (cycle %0d)", en, cyc);
        end else begin
          e = exp_q.pop_front();
          check("enable_code", code, e.code);
          check("enable_cycle", cyc, e.cyc);
          check("busy_with_enable", 32'(oBusy), 1);
        end
        if (code == 7) busy_chk = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int unsigned lc;
    bit ok;

    #2 check_quiet("reset");
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b1;
    @(posedge iClk);
    #1 check_quiet("idle_norun");

    // Run start without sync, fixed 3-cycle stage latency.
    @(posedge iClk);
    #1 iRun = 1'b1;
    push_exp(1, cyc + 1);
    run_seq(3, 0, lc, ok);
    n_done++;

    for (int s = 0; s < 8; s++) begin
      start_sync($urandom_range(1, 4));
      run_seq(0, 0, lc, ok);
      n_done++;
    end

    start_sync(2);
    run_seq(0, 3, lc, ok);
    n_done++;

    // iRun falls mid-sequence: completes, then divider restarts.
    start_sync(1);
    run_seq(0, 5, lc, ok);
    n_done++;
    repeat (3) @(posedge iClk);
    #1 check("busy_run_low", 32'(oBusy), 0);
    n_done = 0;
    iRun = 1'b1;
    push_exp(1, cyc + 1);
    run_seq(0, 0, lc, ok);
    n_done++;

    // Timeout with PARK done withheld.
    start_sync(2);
    run_seq(0, 1, lc, ok);
    repeat (TO) @(negedge iClk);
    check("fault_early", 32'(oFault), 0);
    @(negedge iClk);
    check("fault_set", 32'(oFault), 1);
    check("fault_stage", 32'(oFault_stage), 3);
    check("busy_in_fault", 32'(oBusy), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk);
      #1 iSync = 1'b1;
      @(posedge iClk);
      #1 iSync = 1'b0;
    end
    repeat (4) @(posedge iClk);
    #1 check("fault_held", 32'(oFault), 1);
    check("overrun_after_fault", 32'(oOverrun_cnt), ovr_exp);
    iFault_clr = 1'b1;
    push_exp(1, cyc + 2);
    @(posedge iClk);
    #1 iFault_clr = 1'b0;
    check("fault_cleared", 32'(oFault), 0);
    check("fault_stage_cleared", 32'(oFault_stage), 0);
    run_seq(0, 0, lc, ok);
    n_done++;

    // Sync bursts while CLARK is pending drive the overrun counter to saturation.
    for (int s = 0; s < 38; s++) begin
      start_sync($urandom_range(1, 3));
      run_seq(0, 2, lc, ok);
      n_done++;
      check("overrun_cnt", 32'(oOverrun_cnt), ovr_exp);
    end
    check("overrun_saturated", 32'(oOverrun_cnt), 255);

    // Asynchronous reset while CUR is in progress.
    start_sync(1);
    run_seq(0, 4, lc, ok);
    #2 iRst_n = 1'b0;
    #1 check_quiet("async_reset");
    exp_q.delete();
    n_done = 0;
    ovr_exp = 0;
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b1;
    push_exp(1, cyc + 1);
    run_seq(0, 0, lc, ok);
    n_done++;
    check("overrun_after_reset", 32'(oOverrun_cnt), 0);

    repeat (5) @(posedge iClk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
